axi_sync_align_gate: RTL



---
 rtl/axi_sync_align_gate.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/axi_sync_align_gate.sv
// ----------------------------------------------------------------------------
// axi_sync_align_gate
//
// Per-port packet-boundary gate placed in front of a multi-port AXI-stream
// synchroniser. After reset, clear or a resync request every port discards
// (DROP) or stalls (HOLD) until it sits on a packet boundary; once every port
// is holding, all ports are released into PASS on the same clock so the
// downstream synchroniser sees packet-aligned streams. In PASS the gate is a
// zero-latency pass-through with per-port flow control.
//
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   clear              synchronous clear, same effect as reset
//   resync             one-cycle pulse: re-align at the next packet boundary
//   i_tdata/i_tlast/i_tvalid/i_tready   upstream AXI-stream, SIZE ports packed
//   o_tdata/o_tlast/o_tvalid/o_tready   downstream AXI-stream, same packing
//   aligned            registered: every port is in PASS
//   drop_cnt           per-port saturating count of discarded beats
// ----------------------------------------------------------------------------
module axi_sync_align_gate #(
    parameter int SIZE          = 2,
    parameter int WIDTH         = 32,
    parameter int START_ALIGNED = 1,
    parameter int CNT_W         = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  resync,
    input  logic [SIZE*WIDTH-1:0] i_tdata,
    input  logic [SIZE-1:0]       i_tlast,
    input  logic [SIZE-1:0]       i_tvalid,
    output logic [SIZE-1:0]       i_tready,
    output logic [SIZE*WIDTH-1:0] o_tdata,
    output logic [SIZE-1:0]       o_tlast,
    output logic [SIZE-1:0]       o_tvalid,
    input  logic [SIZE-1:0]       o_tready,
    output logic                  aligned,
    output logic [SIZE*CNT_W-1:0] drop_cnt
);

    typedef enum logic [1:0] {ST_DROP, ST_HOLD, ST_PASS} state_t;

    localparam state_t           RST_ST  = (START_ALIGNED != 0) ? ST_HOLD : ST_DROP;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t                 st_q [SIZE];
    state_t                 st_d [SIZE];
    logic [SIZE-1:0]        in_pkt_q, in_pkt_d;
    logic [SIZE-1:0]        pend_q, pend_d;
    logic [SIZE*CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
    logic                   aligned_q, aligned_d;
    logic [SIZE-1:0]        en;
    logic [SIZE-1:0]        hs;
    logic                   all_hold;
    logic                   all_pass_d;

    // Data and last are never touched; only valid/ready are gated.
    assign o_tdata  = i_tdata;
    assign o_tlast  = i_tlast;
    assign aligned  = aligned_q;
    assign drop_cnt = drop_cnt_q;

    always_comb begin : flow
        all_hold = 1'b1;
        en       = '0;
        i_tready = '0;
        o_tvalid = '0;
        hs       = '0;
        for (int p = 0; p < SIZE; p++) begin
            if (st_q[p] != ST_HOLD) begin
                all_hold = 1'b0;
            end
            // A pending resync at a packet boundary closes the port at once.
            en[p] = (st_q[p] == ST_PASS) && !(pend_q[p] && !in_pkt_q[p]);
            if (st_q[p] == ST_DROP) begin
                i_tready[p] = 1'b1;
            end else if (en[p]) begin
                i_tready[p] = o_tready[p];
            end
            o_tvalid[p] = en[p] & i_tvalid[p];
            hs[p]       = i_tvalid[p] & i_tready[p];
        end
    end

    always_comb begin : next_state
        st_d       = st_q;
        in_pkt_d   = in_pkt_q;
        pend_d     = pend_q;
        drop_cnt_d = drop_cnt_q;
        all_pass_d = 1'b1;
        if (clear) begin
            for (int p = 0; p < SIZE; p++) begin
                st_d[p] = RST_ST;
            end
            in_pkt_d   = '0;
            pend_d     = '0;
            drop_cnt_d = '0;
        end else begin
            for (int p = 0; p < SIZE; p++) begin
                case (st_q[p])
                    ST_DROP: begin
                        if (hs[p]) begin
                            if (drop_cnt_q[p*CNT_W +: CNT_W] != CNT_MAX) begin
                                drop_cnt_d[p*CNT_W +: CNT_W] =
                                    drop_cnt_q[p*CNT_W +: CNT_W] + CNT_W'(1);
                            end
                            if (i_tlast[p]) begin
                                st_d[p] = ST_HOLD;
                            end
                        end
                    end
                    ST_HOLD: begin
                        // Release is collective: every port leaves HOLD together.
                        if (all_hold) begin
                            st_d[p] = ST_PASS;
                        end
                    end
                    ST_PASS: begin
                        if (pend_q[p] && !in_pkt_q[p]) begin
                            st_d[p]   = ST_HOLD;
                            pend_d[p] = 1'b0;
                        end else begin
                            if (hs[p]) begin
                                in_pkt_d[p] = !i_tlast[p];
                            end
                            if (resync) begin
                                pend_d[p] = 1'b1;
                            end
                        end
                    end
                    default: st_d[p] = RST_ST;
                endcase
            end
        end
        for (int p = 0; p < SIZE; p++) begin
            if (st_d[p] != ST_PASS) begin
                all_pass_d = 1'b0;
            end
        end
        aligned_d = all_pass_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int p = 0; p < SIZE; p++) begin
                st_q[p] <= RST_ST;
            end
            in_pkt_q   <= '0;
            pend_q     <= '0;
            drop_cnt_q <= '0;
            aligned_q  <= 1'b0;
        end else begin
            for (int p = 0; p < SIZE; p++) begin
                st_q[p] <= st_d[p];
            end
            in_pkt_q   <= in_pkt_d;
            pend_q     <= pend_d;
            drop_cnt_q <= drop_cnt_d;
            aligned_q  <= aligned_d;
        end
    end

endmodule
